sum3_rx: RTL and testbench



---
 rtl/sum3_rx.sv | 105 ++++++++++
 tb/tb_sum3_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sum3_rx.sv
// sum3_rx: operand-stream receiver for the small-adder test path.
// Collects groups of N unsigned W-bit operands over a valid/ready input,
// sums each group modulo 2^W, and presents the sum on a valid/ready output.
// out_ovf is set when any carry out of bit W-1 occurred within the group.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready depends on state only
//   in_data [W-1:0]   operand
//   abort             synchronous: drop partial group and any held result
//   out_valid/out_ready result handshake
//   out_sum [W-1:0]   group sum mod 2^W
//   out_ovf           sticky carry flag for the group
//   group_cnt [CW-1:0] results consumed downstream, wraps mod 2^CW
//
// state | meaning
// ACC   | accepting operands, accumulating the current group
// HOLD  | result presented, waiting for out_ready
module sum3_rx #(
  parameter int W  = 5,
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_ovf,
  output logic [CW-1:0] group_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q;
  logic [W-1:0]   acc_q;
  logic           ovf_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   sum_q;
  logic           sum_ovf_q;
  logic [CW-1:0]  cnt_q;

  // Extra bit captures the carry out of the W-bit accumulator.
  logic [W:0]     sum_d;
  assign sum_d = {1'b0, acc_q} + {1'b0, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
      cnt_q     <= '0;
    end else if (abort) begin
      // Held result is discarded even if out_ready is high; the count stays.
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (idx_q == LAST_IDX) begin
              sum_q     <= sum_d[W-1:0];
              sum_ovf_q <= ovf_q | sum_d[W];
              acc_q     <= '0;
              ovf_q     <= 1'b0;
              idx_q     <= '0;
              state_q   <= HOLD;
            end else begin
              acc_q <= sum_d[W-1:0];
              ovf_q <= ovf_q | sum_d[W];
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_ovf   = sum_ovf_q;
  assign group_cnt = cnt_q;

endmodule

// File: tb/tb_sum3_rx.sv
// Testbench for sum3_rx: directed groups with hand-computed sums pushed to a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_sum3_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic       abort = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_sum;
  logic       out_ovf;
  logic [7:0] group_cnt;

  typedef struct {
    logic [4:0] sum;
    logic       ovf;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cnt_model = '0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         rand_ready = 1'b0;

  sum3_rx #(.W(5), .N(3), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .group_cnt(group_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a real handshake is out_valid & out_ready with no abort/rst.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", int'(out_sum), int'(e.sum));
        chk("out_ovf", int'(out_ovf), int'(e.ovf));
        chk("group_cnt_pre", int'(group_cnt), int'(e.cnt));
      end
    end
  end

  task automatic send(input logic [4:0] d, input bit gaps);
    bit done;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic group(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [4:0] s,
                       input logic o, input bit gaps);
    exp_t e;
    e.sum = s; e.ovf = o; e.cnt = cnt_model;
    exp_q.push_back(e);
    cnt_model = cnt_model + 8'd1;
    send(a, gaps); send(b, gaps); send(c, gaps);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_sum"}, int'(out_sum), 0);
    chk({tag, "_out_ovf"}, int'(out_ovf), 0);
    chk({tag, "_group_cnt"}, int'(group_cnt), 0);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1+3+2: out_valid rises right after the third accept, lasts one cycle.
    begin
      exp_t e;
      e.sum = 5'd6; e.ovf = 1'b0; e.cnt = cnt_model;
      exp_q.push_back(e);
      cnt_model = cnt_model + 8'd1;
    end
    send(5'd1, 0); send(5'd3, 0); send(5'd2, 0);
    chk("latency_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    chk("single_cycle_valid", int'(out_valid), 0);
    chk("cnt_after_g1", int'(group_cnt), 1);
    group(5'd1, 5'd2, 5'd3, 5'd6, 1'b0, 0);
    drain();
    chk("cnt_after_g2", int'(group_cnt), 2);

    // Overflow, then confirm the flag clears per group.
    group(5'd20, 5'd10, 5'd5, 5'd3, 1'b1, 0);
    group(5'd1, 5'd1, 5'd1, 5'd3, 1'b0, 0);
    drain();

    // Backpressure: result held, no operand consumed while in HOLD.
    out_ready = 1'b0;
    group(5'd5, 5'd6, 5'd7, 5'd18, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_sum", int'(out_sum), 18);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_cnt_once", int'(group_cnt), int'(cnt_model));
    chk("bp_ready_after", int'(in_ready), 1);
    group(5'd9, 5'd1, 5'd1, 5'd11, 1'b0, 0);
    drain();

    // Async reset mid-group.
    send(5'd7, 0); send(5'd9, 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_model = '0;
    group(5'd1, 5'd1, 5'd1, 5'd3, 1'b0, 0);
    drain();

    // Abort mid-group drops the partial sum and the same-cycle operand.
    send(5'd4, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 5'd8;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    group(5'd2, 5'd2, 5'd2, 5'd6, 1'b0, 0);
    drain();

    // Abort in HOLD with out_ready high: result discarded, count unchanged.
    out_ready = 1'b0;
    send(5'd1, 0); send(5'd2, 0); send(5'd3, 0);
    chk("hold_before_abort", int'(out_valid), 1);
    out_ready = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_hold_valid", int'(out_valid), 0);
    chk("abort_hold_cnt", int'(group_cnt), int'(cnt_model));

    // 256 zero groups with random gaps; counter wraps back to 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_model = '0;
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int g = 0; g < 256; g++) group(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1);
    rand_ready = 1'b0;
    drain();
    chk("wrap_cnt", int'(group_cnt), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
